// File: rtl/branch_ctrl_if.sv
// Decode-to-branch-controller bundle: branch request handshake, comparator
// drive/result, redirect/flush/stall pipeline controls and statistics.
// master = decode/comparator side, slave = branch_ctrl.
interface branch_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   // decode -> controller request
   logic                  br_valid;
   logic                  br_ready;
   logic [DATA_WIDTH-1:0] br_pc;
   logic [DATA_WIDTH-1:0] br_imm;
   logic [DATA_WIDTH-1:0] br_rs1;
   logic [DATA_WIDTH-1:0] br_rs2;
   logic [2:0]            br_func3;
   // comparator interface
   logic [DATA_WIDTH-1:0] cmp_read1;
   logic [DATA_WIDTH-1:0] cmp_read2;
   logic [2:0]            cmp_branchType;
   logic                  cmp_branchN;
   // pipeline control
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_pc;
   logic                  flush;
   logic                  stall;
   logic                  illegal_func3;
   logic                  misaligned;
   // statistics
   logic                  cnt_clear;
   logic [CNT_WIDTH-1:0]  branch_cnt;
   logic [CNT_WIDTH-1:0]  taken_cnt;

   modport master (
      output br_valid, br_pc, br_imm, br_rs1, br_rs2, br_func3, cmp_branchN, cnt_clear,
      input  br_ready, cmp_read1, cmp_read2, cmp_branchType, redirect_valid, redirect_pc,
             flush, stall, illegal_func3, misaligned, branch_cnt, taken_cnt
   );

   modport slave (
      input  br_valid, br_pc, br_imm, br_rs1, br_rs2, br_func3, cmp_branchN, cnt_clear,
      output br_ready, cmp_read1, cmp_read2, cmp_branchType, redirect_valid, redirect_pc,
             flush, stall, illegal_func3, misaligned, branch_cnt, taken_cnt
   );
endinterface

// File: rtl/branch_ctrl.sv
// Execute-stage branch sequencer: captures one branch, drives the comparator, redirects/flushes on taken.
// Latency: EVAL in cycle 1 after accept, redirect pulse in cycle 2, ready again in 2 (not taken) or 2+FLUSH_CYCLES.
// Backpressure: br_ready only in IDLE; br_valid may be held and is taken on the first IDLE cycle.
// Ports: clk, rst (async active-high); bus (branch_ctrl_if.slave) carries the br_* request,
//        cmp_* comparator drive/result, redirect/flush/stall/illegal/misaligned pulses and statistics.
module branch_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input logic          clk,
   input logic          rst,
   branch_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] EVAL     = 2'd1;
   localparam logic [1:0] REDIRECT = 2'd2;
   localparam logic [1:0] FLUSH    = 2'd3;

   // REDIRECT itself is the first flush cycle, so the counter starts one short.
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] imm_q;
   logic [DATA_WIDTH-1:0] rs1_q;
   logic [DATA_WIDTH-1:0] rs2_q;
   logic [2:0]            func3_q;
   logic [DATA_WIDTH-1:0] redirect_pc_q;
   logic [3:0]            flush_cnt;
   logic [CNT_WIDTH-1:0]  branch_cnt_q;
   logic [CNT_WIDTH-1:0]  taken_cnt_q;

   logic                  in_eval;
   logic                  func3_bad;
   logic                  legal_eval;
   logic                  taken;
   logic [DATA_WIDTH-1:0] target;
   logic                  target_misal;

   // func3 010/011 are the unassigned B-type encodings.
   assign in_eval      = (state == EVAL);
   assign func3_bad    = (func3_q[2:1] == 2'b01);
   assign legal_eval   = in_eval && !func3_bad;
   assign taken        = legal_eval && bus.cmp_branchN;
   assign target       = pc_q + imm_q;
   assign target_misal = (target[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         pc_q          <= '0;
         imm_q         <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         func3_q       <= '0;
         redirect_pc_q <= '0;
         flush_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.br_valid) begin
                  pc_q    <= bus.br_pc;
                  imm_q   <= bus.br_imm;
                  rs1_q   <= bus.br_rs1;
                  rs2_q   <= bus.br_rs2;
                  func3_q <= bus.br_func3;
                  state   <= EVAL;
               end
            end
            EVAL: begin
               // Misaligned taken targets are reported but never redirected.
               if (taken && !target_misal) begin
                  redirect_pc_q <= target;
                  flush_cnt     <= FLUSH_LOAD;
                  state         <= REDIRECT;
               end else begin
                  state <= IDLE;
               end
            end
            REDIRECT: begin
               state <= (flush_cnt == 4'd0) ? IDLE : FLUSH;
            end
            FLUSH: begin
               flush_cnt <= flush_cnt - 4'd1;
               if (flush_cnt == 4'd1) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Statistics: clear wins over a same-cycle increment; both saturate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else if (bus.cnt_clear) begin
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else begin
         if (legal_eval && (branch_cnt_q != '1)) begin
            branch_cnt_q <= branch_cnt_q + 1'b1;
         end
         if (taken && (taken_cnt_q != '1)) begin
            taken_cnt_q <= taken_cnt_q + 1'b1;
         end
      end
   end

   assign bus.br_ready       = (state == IDLE);
   assign bus.stall          = (state != IDLE);
   assign bus.flush          = (state == REDIRECT) || (state == FLUSH);
   assign bus.redirect_valid = (state == REDIRECT);
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.cmp_read1      = rs1_q;
   assign bus.cmp_read2      = rs2_q;
   assign bus.cmp_branchType = func3_q;
   assign bus.illegal_func3  = in_eval && func3_bad;
   assign bus.misaligned     = taken && target_misal;
   assign bus.branch_cnt     = branch_cnt_q;
   assign bus.taken_cnt      = taken_cnt_q;
endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
   localparam int DW  = 32;
   localparam int FC  = 2;
   localparam int CW  = 4;
   localparam int MAXC = (1 << CW) - 1;

   localparam int K_NT  = 0;  // not taken
   localparam int K_TK  = 1;  // taken, aligned -> redirect
   localparam int K_MIS = 2;  // taken, misaligned
   localparam int K_ILL = 3;  // illegal func3

   typedef struct {
      int          ill;
      int          mis;
      int          redir;
      logic [31:0] rpc;
      int          flush_n;
      int          lat;
      int          bcnt;
      int          tcnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int m_b = 0;
   int m_t = 0;
   exp_t exp_q[$];

   branch_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   branch_ctrl #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference RISC-V branch comparator.
   function automatic logic cmp_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      case (f)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) <  $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a <  b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   always_comb bus.cmp_branchN = cmp_model(bus.cmp_read1, bus.cmp_read2, bus.cmp_branchType);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive a branch and hold valid until accepted; returns 1ns into cycle 1.
   task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2, input bit clr);
      int guard = 0;
      bit acc = 1'b0;
      bus.br_valid = 1'b1;
      bus.br_func3 = f3;
      bus.br_pc    = pc;
      bus.br_imm   = imm;
      bus.br_rs1   = rs1;
      bus.br_rs2   = rs2;
      do begin
         @(negedge clk);
         acc = bus.br_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("accept_timeout", 64'(guard), 64'd0);
      bus.br_valid = 1'b0;
      if (clr) begin
         bus.cnt_clear = 1'b1;
         @(posedge clk);
         #1;
         bus.cnt_clear = 1'b0;
      end
   endtask

   // Push the hand-derived expectation, then issue the branch.
   task automatic vec(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic [31:0] rs2, input bit clr,
                      input int kind, input logic [31:0] tgt);
      exp_t e;
      if (clr) begin
         m_b = 0;
         m_t = 0;
      end else if (kind != K_ILL) begin
         if (m_b < MAXC) m_b++;
         if ((kind == K_TK || kind == K_MIS) && m_t < MAXC) m_t++;
      end
      e.ill     = (kind == K_ILL) ? 1 : 0;
      e.mis     = (kind == K_MIS) ? 1 : 0;
      e.redir   = (kind == K_TK) ? 1 : 0;
      e.rpc     = tgt;
      e.flush_n = (kind == K_TK) ? FC : 0;
      e.lat     = (kind == K_TK) ? 2 + FC : 2;
      e.bcnt    = m_b;
      e.tcnt    = m_t;
      exp_q.push_back(e);
      issue(f3, pc, imm, rs1, rs2, clr);
   endtask

   // Monitor: observes each accepted branch until br_ready returns, then scores it.
   initial begin : monitor
      bit busy = 1'b0;
      int k = 0;
      int ill_n = 0, ill_cyc = 0, mis_n = 0, mis_cyc = 0;
      int redir_n = 0, redir_cyc = 0, flush_n = 0, stall_n = 0;
      logic [31:0] rpc = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
         end else begin
            if (busy) begin
               k++;
               if (bus.illegal_func3)  begin ill_n++;   ill_cyc = k;   end
               if (bus.misaligned)     begin mis_n++;   mis_cyc = k;   end
               if (bus.redirect_valid) begin redir_n++; redir_cyc = k; rpc = bus.redirect_pc; end
               if (bus.flush) flush_n++;
               if (bus.stall) stall_n++;
               if (bus.br_ready) begin
                  busy = 1'b0;
                  if (exp_q.size() == 0) begin
                     chk("queue_underflow", 64'd1, 64'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("illegal_pulses", 64'(ill_n),  64'(e.ill));
                     chk("illegal_cycle",  64'(ill_cyc), 64'(e.ill));
                     chk("misal_pulses",   64'(mis_n),  64'(e.mis));
                     chk("misal_cycle",    64'(mis_cyc), 64'(e.mis));
                     chk("redirect_pulses", 64'(redir_n), 64'(e.redir));
                     if (e.redir != 0) begin
                        chk("redirect_cycle", 64'(redir_cyc), 64'd2);
                        chk("redirect_pc",    64'(rpc),       64'(e.rpc));
                     end
                     chk("flush_cycles",  64'(flush_n), 64'(e.flush_n));
                     chk("ready_latency", 64'(k),       64'(e.lat));
                     chk("stall_cycles",  64'(stall_n), 64'(e.lat - 1));
                     chk("branch_cnt",    64'(bus.branch_cnt), 64'(e.bcnt));
                     chk("taken_cnt",     64'(bus.taken_cnt),  64'(e.tcnt));
                  end
               end else if (k >= 40) begin
                  busy = 1'b0;
                  chk("ready_timeout", 64'(k), 64'd0);
               end
            end
            if (!busy && bus.br_valid && bus.br_ready) begin
               busy = 1'b1;
               k = 0;
               ill_n = 0; ill_cyc = 0; mis_n = 0; mis_cyc = 0;
               redir_n = 0; redir_cyc = 0; flush_n = 0; stall_n = 0;
            end
         end
      end
   end

   initial begin : driver
      int guard;
      bus.br_valid  = 1'b0;
      bus.br_pc     = '0;
      bus.br_imm    = '0;
      bus.br_rs1    = '0;
      bus.br_rs2    = '0;
      bus.br_func3  = '0;
      bus.cnt_clear = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_br_ready", 64'(bus.br_ready),       64'd1);
      chk("rst_stall",    64'(bus.stall),          64'd0);
      chk("rst_flush",    64'(bus.flush),          64'd0);
      chk("rst_redirect", 64'(bus.redirect_valid), 64'd0);
      chk("rst_illegal",  64'(bus.illegal_func3),  64'd0);
      chk("rst_misal",    64'(bus.misaligned),     64'd0);
      chk("rst_bcnt",     64'(bus.branch_cnt),     64'd0);
      chk("rst_tcnt",     64'(bus.taken_cnt),      64'd0);
      chk("rst_rpc",      64'(bus.redirect_pc),    64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      //  func3   pc            imm           rs1           rs2          clr  kind   target
      vec(3'b000, 32'h100,      32'h20,       32'd5,        32'd6,       0,   K_NT,  32'h120);
      vec(3'b001, 32'h100,      32'hFFFFFFF0, 32'd1,        32'd2,       0,   K_TK,  32'h0F0);
      vec(3'b000, 32'hFFFFFFFC, 32'h8,        32'd7,        32'd7,       0,   K_TK,  32'h004);
      vec(3'b001, 32'h100,      32'h22,       32'd1,        32'd2,       0,   K_MIS, 32'h122);
      vec(3'b011, 32'h100,      32'h20,       32'd1,        32'd1,       0,   K_ILL, 32'h120);
      vec(3'b010, 32'h100,      32'h20,       32'd1,        32'd1,       0,   K_ILL, 32'h120);
      vec(3'b100, 32'h200,      32'h40,       32'hFFFFFFFF, 32'd1,       0,   K_TK,  32'h240);
      vec(3'b110, 32'h200,      32'h40,       32'hFFFFFFFF, 32'd1,       0,   K_NT,  32'h240);
      vec(3'b101, 32'h1000,     32'hFFFFFFFC, 32'd3,        32'd3,       0,   K_TK,  32'h0FFC);
      vec(3'b111, 32'h300,      32'h10,       32'd2,        32'd9,       0,   K_NT,  32'h310);

      // Drive both counters into saturation, then a not-taken at saturation.
      for (int i = 0; i < 12; i++) begin
         vec(3'b000, 32'h400, 32'h10, 32'd9, 32'd9, 0, K_TK, 32'h410);
      end
      vec(3'b001, 32'h400, 32'h10, 32'd9, 32'd9, 0, K_NT, 32'h410);

      // Clear coincident with a taken EVAL: clear wins, redirect still happens.
      vec(3'b001, 32'h500, 32'h8, 32'd1, 32'd0, 1, K_TK, 32'h508);
      vec(3'b000, 32'h600, 32'h4, 32'd4, 32'd4, 0, K_TK, 32'h604);

      // Let the scoreboard drain before the reset-mid-flush case.
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      chk("drain_before_reset", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;

      // Reset mid-flush: not scoreboarded, checked directly.
      issue(3'b000, 32'h700, 32'h10, 32'd1, 32'd1, 1'b0);
      @(posedge clk);   // REDIRECT
      @(posedge clk);   // FLUSH
      #2;
      chk("pre_rst_flush", 64'(bus.flush), 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_flush",    64'(bus.flush),          64'd0);
      chk("midrst_stall",    64'(bus.stall),          64'd0);
      chk("midrst_redirect", 64'(bus.redirect_valid), 64'd0);
      chk("midrst_ready",    64'(bus.br_ready),       64'd1);
      chk("midrst_bcnt",     64'(bus.branch_cnt),     64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_b = 0;
      m_t = 0;

      vec(3'b000, 32'h100, 32'h20, 32'd5, 32'd6, 0, K_NT, 32'h120);
      vec(3'b001, 32'h800, 32'h1C, 32'd5, 32'd6, 0, K_TK, 32'h81C);

      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      chk("final_drain", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequencing controller for the branch comparator in the execute stage.
- Accepts one branch at a time from decode over a valid/ready handshake and registers its operands.
- Drives the comparator from those registers, samples the taken/not-taken decision, and computes the target as pc + imm.
- On a taken branch it issues a one-cycle PC redirect and holds a pipeline flush for a parameterised number of cycles; it also keeps saturating branch statistics.

Parameters:
- DATA_WIDTH, 32, width of PC, immediate and register operands.
- FLUSH_CYCLES, 2, cycles flush is asserted per taken branch; legal range 1..15.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- br_valid  input  1  decode presents a branch.
- br_ready  output  1  controller can accept a branch.
- br_pc  input  DATA_WIDTH  PC of the branch instruction.
- br_imm  input  DATA_WIDTH  sign-extended B-type immediate.
- br_rs1  input  DATA_WIDTH  rs1 operand value.
- br_rs2  input  DATA_WIDTH  rs2 operand value.
- br_func3  input  3  branch func3.
- cmp_read1  output  DATA_WIDTH  comparator operand 1 (registered rs1).
- cmp_read2  output  DATA_WIDTH  comparator operand 2 (registered rs2).
- cmp_branchType  output  3  comparator branch type (registered func3).
- cmp_branchN  input  1  comparator taken result, combinational from cmp_* outputs.
- redirect_valid  output  1  one-cycle pulse: fetch loads redirect_pc.
- redirect_pc  output  DATA_WIDTH  branch target.
- flush  output  1  kill younger instructions in IF/ID.
- stall  output  1  hold decode; high whenever the FSM is not in IDLE.
- illegal_func3  output  1  one-cycle pulse for func3 010 or 011.
- misaligned  output  1  one-cycle pulse: taken target with target[1:0] != 0.
- cnt_clear  input  1  synchronous clear of both statistics counters.
- branch_cnt  output  CNT_WIDTH  number of resolved legal branches.
- taken_cnt  output  CNT_WIDTH  number of taken legal branches.

Behaviour:
- Reset values, applied immediately on rst high:
  - FSM returns to IDLE; operand, target and flush-counter registers clear to 0.
  - br_ready = 1.
  - redirect_valid, flush, stall, illegal_func3, misaligned = 0.
  - branch_cnt, taken_cnt = 0.
- States: IDLE, EVAL, REDIRECT, FLUSH.
- Output decode from state:
  - br_ready = (state == IDLE).
  - stall = (state != IDLE).
  - flush = state in {REDIRECT, FLUSH}.
  - redirect_valid = (state == REDIRECT).
- IDLE:
  - On br_valid & br_ready, capture pc, imm, rs1, rs2 and func3, then go to EVAL.
  - With br_valid low, stay in IDLE; captured registers hold their values.
- EVAL (exactly one cycle):
  - cmp_* outputs are the captured values.
  - target = pc + imm, modulo 2^DATA_WIDTH; carry is discarded.
  - Illegal func3 (010, 011): pulse illegal_func3, treat as not-taken, no counter update, go to IDLE.
  - Legal func3 with cmp_branchN = 0: branch_cnt++, go to IDLE.
  - Legal func3 with cmp_branchN = 1 and target[1:0] != 0: branch_cnt++, taken_cnt++, pulse misaligned, no redirect or flush, go to IDLE.
  - Legal func3 with cmp_branchN = 1 and aligned target: branch_cnt++, taken_cnt++, register redirect_pc = target, load flush counter with FLUSH_CYCLES-1, go to REDIRECT.
- REDIRECT (one cycle):
  - redirect_valid and flush are high.
  - If counter == 0, go to IDLE; otherwise go to FLUSH.
- FLUSH:
  - flush is high; counter decrements each cycle.
  - When counter reaches 1, go to IDLE on the next edge. Total flush high time is FLUSH_CYCLES cycles, starting at REDIRECT.
- redirect_pc holds its last target outside REDIRECT.
- Latency, with handshake on edge 0:
  - EVAL occupies cycle 1.
  - redirect_valid is high in cycle 2.
  - br_ready returns high in cycle 2 (not-taken) or cycle 2+FLUSH_CYCLES (taken).
- There are no back-to-back accepts: a new branch can be accepted only in IDLE. br_valid may stay high and is accepted on the first IDLE cycle.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clear has priority over an increment in the same cycle; the counter reads 0 next cycle.
- Reset mid-operation: immediate return to IDLE. The in-flight branch is dropped and any redirect or flush is cancelled.

Test Plan:
- Not-taken: BEQ with rs1=5, rs2=6, pc=0x100, imm=0x20 (comparator returns 0) -> no redirect, flush stays 0, br_ready high in cycle 2, branch_cnt=1, taken_cnt=0.
- Taken: BNE with rs1=1, rs2=2, pc=0x100, imm=0xFFFFFFF0 -> redirect_valid pulses in cycle 2 with redirect_pc=0xF0, flush high in cycles 2-3 (FLUSH_CYCLES=2), br_ready=0 in cycles 1-3.
- Wrap and misalignment: pc=0xFFFFFFFC, imm=8, taken -> aligned target 0x00000004 is redirected. Separately, imm=0x22 with pc=0x100, taken -> misaligned pulses, no redirect, taken_cnt increments.
- Illegal: func3=011 -> illegal_func3 pulses in cycle 1, counters unchanged, back to IDLE in cycle 2.
- Saturation and clear: preload via 0xFFFF taken branches (or CNT_WIDTH=4 with 15) -> counter holds at max. Assert cnt_clear together with a taken EVAL -> both counters read 0.
- Reset mid-flush: assert rst during FLUSH -> flush, stall and redirect_valid drop to 0 immediately, br_ready=1. The next branch after reset is accepted normally.
